rpf64_arbiter: RTL and testbench

RPF64_ARBITER -- requirements
Module: rpf64_arbiter

---
 rtl/rpf64_arbiter.sv | 179 +++++++++++++++++
 tb/tb_rpf64_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rpf64_arbiter.sv
// rpf64_arbiter: round-robin front end sharing one roundAndPackFloat64 engine among NREQ requesters
// Ports: ap_clk / ap_rst       clock, asynchronous active-high reset
//        req_valid/req_ready   per-requester request and one-cycle grant pulse
//        req_sign/exp/sig      flat-packed operands, requester i at slice i
//        rsp_*                 result handshake with requester id and newly raised flags
//        eng_*                 ap_ctrl_hs control, operands, result and flag path of the engine
//        flag_clr              clears sticky_flags; ops_done counts completed operations
module rpf64_arbiter #(
    parameter int NREQ = 4
) (
    input  logic               ap_clk,
    input  logic               ap_rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_sign,
    input  logic [NREQ*13-1:0] req_exp,
    input  logic [NREQ*64-1:0] req_sig,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [63:0]        rsp_data,
    output logic [2:0]         rsp_id,
    output logic [31:0]        rsp_flags,
    output logic               eng_start,
    input  logic               eng_ready,
    input  logic               eng_done,
    input  logic               eng_idle,
    output logic               eng_zSign,
    output logic [12:0]        eng_zExp,
    output logic [63:0]        eng_zSig,
    input  logic [63:0]        eng_return,
    output logic [31:0]        eng_flag_i,
    input  logic [31:0]        eng_flag_o,
    input  logic               eng_flag_o_vld,
    input  logic               flag_clr,
    output logic [31:0]        sticky_flags,
    output logic [15:0]        ops_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            eng_start_q, eng_start_d;
    logic            zsign_q, zsign_d;
    logic [12:0]     zexp_q, zexp_d;
    logic [63:0]     zsig_q, zsig_d;
    logic [2:0]      id_q, id_d, last_q, last_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [63:0]     rsp_data_q, rsp_data_d;
    logic [31:0]     rsp_flags_q, rsp_flags_d, sticky_q, sticky_d, new_flags;
    logic [15:0]     ops_q, ops_d;
    logic            gnt_any;
    logic [2:0]      gnt_idx;
    logic            sel_sign;
    logic [12:0]     sel_exp;
    logic [63:0]     sel_sig;
    logic            eng_idle_unused;

    // eng_idle is observation-only
    assign eng_idle_unused = eng_idle;

    assign req_ready    = req_ready_q;
    assign eng_start    = eng_start_q;
    assign eng_zSign    = zsign_q;
    assign eng_zExp     = zexp_q;
    assign eng_zSig     = zsig_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_id       = id_q;
    assign rsp_flags    = rsp_flags_q;
    assign sticky_flags = sticky_q;
    assign eng_flag_i   = sticky_q;
    assign ops_done     = ops_q;
    assign new_flags    = eng_flag_o & ~sticky_q;

    // Search starts one past the last completed grant so every requester gets a turn
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        sel_sign = 1'b0;
        sel_exp  = '0;
        sel_sig  = '0;
        for (int k = 1; k <= NREQ; k++)
            for (int i = 0; i < NREQ; i++)
                if (!gnt_any && req_valid[i] && (int'(last_q) + k) % NREQ == i) begin
                    gnt_any = 1'b1;
                    gnt_idx = 3'(i);
                end
        for (int i = 0; i < NREQ; i++)
            if (gnt_idx == 3'(i)) begin
                sel_sign = req_sign[i];
                sel_exp  = req_exp[i*13 +: 13];
                sel_sig  = req_sig[i*64 +: 64];
            end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        eng_start_d = eng_start_q;
        zsign_d     = zsign_q;
        zexp_d      = zexp_q;
        zsig_d      = zsig_q;
        id_d        = id_q;
        last_d      = last_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        sticky_d    = sticky_q;
        ops_d       = ops_q;
        unique case (state_q)
            IDLE: if (gnt_any) begin
                req_ready_d = NREQ'(1) << gnt_idx;
                zsign_d     = sel_sign;
                zexp_d      = sel_exp;
                zsig_d      = sel_sig;
                id_d        = gnt_idx;
                rsp_flags_d = '0;
                eng_start_d = 1'b1;
                state_d     = ISSUE;
            end
            ISSUE: if (eng_ready) begin
                eng_start_d = 1'b0;
                rsp_data_d  = eng_done ? eng_return : rsp_data_q;
                rsp_valid_d = eng_done;
                state_d     = eng_done ? RESP : WAIT;
            end
            WAIT: if (eng_done) begin
                rsp_data_d  = eng_return;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                ops_d       = ops_q + 16'd1;
                last_d      = id_q;
                state_d     = IDLE;
            end
        endcase
        // A clear coinciding with new flags keeps only what this operation raised
        if (eng_flag_o_vld) begin
            sticky_d    = flag_clr ? new_flags : eng_flag_o;
            rsp_flags_d = (state_q != RESP) ? new_flags : rsp_flags_d;
        end else if (flag_clr) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            eng_start_q <= 1'b0;
            zsign_q     <= 1'b0;
            zexp_q      <= '0;
            zsig_q      <= '0;
            id_q        <= '0;
            last_q      <= 3'(NREQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            sticky_q    <= '0;
            ops_q       <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            eng_start_q <= eng_start_d;
            zsign_q     <= zsign_d;
            zexp_q      <= zexp_d;
            zsig_q      <= zsig_d;
            id_q        <= id_d;
            last_q      <= last_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            sticky_q    <= sticky_d;
            ops_q       <= ops_d;
        end
    end
endmodule

// File: tb/tb_rpf64_arbiter.sv
// tb_rpf64_arbiter: directed checks of rpf64_arbiter against a behavioural roundAndPackFloat64 engine
module tb_rpf64_arbiter;
    localparam int N = 4;

    logic           ap_clk = 1'b0;
    logic           ap_rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   req_sign = '0;
    logic [N*13-1:0] req_exp = '0;
    logic [N*64-1:0] req_sig = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic [63:0]    rsp_data;
    logic [2:0]     rsp_id;
    logic [31:0]    rsp_flags;
    logic           eng_start, eng_ready, eng_done, eng_idle;
    logic           eng_zSign;
    logic [12:0]    eng_zExp;
    logic [63:0]    eng_zSig, eng_return;
    logic [31:0]    eng_flag_i, eng_flag_o;
    logic           eng_flag_o_vld;
    logic           flag_clr, flag_clr_drv = 1'b0, clr_on_done = 1'b0;
    logic [31:0]    sticky_flags;
    logic [15:0]    ops_done;

    int n_chk = 0, n_pass = 0;
    int lat = 1;
    int cyc = 0;
    logic [N-1:0] gv[$];
    int gc[$];

    rpf64_arbiter #(.NREQ(N)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_sign(req_sign), .req_exp(req_exp), .req_sig(req_sig),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_flags(rsp_flags),
        .eng_start(eng_start), .eng_ready(eng_ready), .eng_done(eng_done), .eng_idle(eng_idle),
        .eng_zSign(eng_zSign), .eng_zExp(eng_zExp), .eng_zSig(eng_zSig), .eng_return(eng_return),
        .eng_flag_i(eng_flag_i), .eng_flag_o(eng_flag_o), .eng_flag_o_vld(eng_flag_o_vld),
        .flag_clr(flag_clr), .sticky_flags(sticky_flags), .ops_done(ops_done)
    );

    always #5 ap_clk = ~ap_clk;
    always @(posedge ap_clk) cyc <= cyc + 1;

    // roundAndPackFloat64, nearest-even, non-negative exponents; flags inexact=1, overflow=4
    function automatic logic [95:0] rpf(input logic s, input logic [12:0] e, input logic [63:0] z);
        logic [63:0] zs, r;
        logic [31:0] f;
        logic [12:0] ee;
        zs = z + 64'h200;
        f  = '0;
        ee = e;
        if (e >= 13'h7FD && (e > 13'h7FD || zs[63])) begin
            f = 32'h5;
            r = {s, 11'h7FF, 52'h0};
        end else begin
            if (z[9:0] != 10'h0) f = 32'h1;
            r = zs >> 10;
            if (z[9:0] == 10'h200) r[0] = 1'b0;
            if (r == 64'h0) ee = '0;
            r = {s, 63'h0} + (64'(ee) << 52) + r;
        end
        return {f, r};
    endfunction

    logic        busy;
    int          cnt;
    logic [63:0] res_l;
    logic [31:0] raised_l;

    assign eng_ready = eng_start && !busy;
    assign eng_idle  = !busy;
    assign flag_clr  = flag_clr_drv | (clr_on_done & eng_done);

    always @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            busy <= 1'b0;
            cnt <= 0;
            eng_done <= 1'b0;
            eng_flag_o_vld <= 1'b0;
            eng_return <= '0;
            eng_flag_o <= '0;
            res_l <= '0;
            raised_l <= '0;
        end else begin
            eng_done <= 1'b0;
            eng_flag_o_vld <= 1'b0;
            if (eng_ready) begin
                busy <= 1'b1;
                cnt <= lat;
                {raised_l, res_l} <= rpf(eng_zSign, eng_zExp, eng_zSig);
            end else if (busy) begin
                if (cnt <= 1) begin
                    busy <= 1'b0;
                    eng_done <= 1'b1;
                    eng_flag_o_vld <= 1'b1;
                    eng_return <= res_l;
                    eng_flag_o <= eng_flag_i | raised_l;
                end else cnt <= cnt - 1;
            end
        end
    end

    always @(negedge ap_clk) if (req_ready != '0) begin
        gv.push_back(req_ready);
        gc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic do_reset();
        ap_rst = 1'b1;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
    endtask

    task automatic set_req(input int i, input logic s, input logic [12:0] e, input logic [63:0] z);
        req_sign[i] = s;
        req_exp[i*13 +: 13] = e;
        req_sig[i*64 +: 64] = z;
        req_valid[i] = 1'b1;
    endtask

    task automatic grant_wait(input int i);
        logic got = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge ap_clk);
            if (req_ready[i]) begin
                got = 1'b1;
                break;
            end
        end
        req_valid[i] = 1'b0;
        chk($sformatf("grant%0d", i), 64'(got), 64'd1);
    endtask

    task automatic wait_rsp();
        for (int c = 0; c < 60; c++) begin
            @(negedge ap_clk);
            if (rsp_valid) break;
        end
        chk("rsp_valid", 64'(rsp_valid), 64'd1);
    endtask

    task automatic accept();
        rsp_ready = 1'b1;
        @(negedge ap_clk);
        rsp_ready = 1'b0;
    endtask

    task automatic op(input int i, input logic s, input logic [12:0] e, input logic [63:0] z,
                      input logic [63:0] xd, input logic [31:0] xf);
        set_req(i, s, e, z);
        grant_wait(i);
        wait_rsp();
        chk($sformatf("rsp_data%0d", i), rsp_data, xd);
        chk($sformatf("rsp_id%0d", i), 64'(rsp_id), 64'(i));
        chk($sformatf("rsp_flags%0d", i), 64'(rsp_flags), 64'(xf));
        accept();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, nv, nd, ng, ns;
        logic seen;
        do_reset();
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_sticky", 64'(sticky_flags), 64'd0);
        chk("rst_ops_done", 64'(ops_done), 64'd0);
        chk("rst_rsp_data", rsp_data, 64'd0);

        op(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 32'h0);
        chk("single_ops_done", 64'(ops_done), 64'd1);

        op(3, 1'b0, 13'h7FD, 64'h7FFF_FFFF_FFFF_FE00, 64'h7FF0_0000_0000_0000, 32'h5);
        chk("ovf_sticky", 64'(sticky_flags), 64'h5);

        flag_clr_drv = 1'b1;
        @(negedge ap_clk);
        flag_clr_drv = 1'b0;
        chk("clr_sticky", 64'(sticky_flags), 64'h0);
        op(1, 1'b0, 13'h3FE, 64'h4000_0000_0000_0001, 64'h3FF0_0000_0000_0000, 32'h1);
        chk("inexact_sticky", 64'(sticky_flags), 64'h1);
        clr_on_done = 1'b1;
        op(2, 1'b0, 13'h7FD, 64'h7FFF_FFFF_FFFF_FE00, 64'h7FF0_0000_0000_0000, 32'h4);
        clr_on_done = 1'b0;
        chk("coinc_sticky", 64'(sticky_flags), 64'h4);
        chk("coinc_flag_i", 64'(eng_flag_i), 64'h4);

        set_req(1, 1'b0, 13'h400, 64'h4000_0000_0000_0000);
        grant_wait(1);
        wait_rsp();
        set_req(2, 1'b1, 13'h3FE, 64'h4000_0000_0000_0000);
        nv = 0; nd = 0; ng = 0; ns = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge ap_clk);
            nv += int'(rsp_valid);
            nd += int'(rsp_data == 64'h4010_0000_0000_0000);
            ng += int'(req_ready != '0);
            ns += int'(eng_start);
        end
        chk("bp_valid_cycles", 64'(nv), 64'd10);
        chk("bp_data_cycles", 64'(nd), 64'd10);
        chk("bp_grants", 64'(ng), 64'd0);
        chk("bp_eng_start", 64'(ns), 64'd0);
        chk("bp_rsp_id", 64'(rsp_id), 64'd1);
        accept();
        grant_wait(2);
        wait_rsp();
        chk("bp_next_data", rsp_data, 64'hBFF0_0000_0000_0000);
        chk("bp_next_id", 64'(rsp_id), 64'd2);
        accept();

        lat = 6;
        set_req(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000);
        grant_wait(0);
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge ap_clk);
            if (!eng_start) begin
                seen = 1'b1;
                break;
            end
        end
        chk("mid_reached_wait", 64'(seen), 64'd1);
        ap_rst = 1'b1;
        #1;
        chk("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rsp_data", rsp_data, 64'd0);
        chk("mid_eng_zsig", eng_zSig, 64'd0);
        chk("mid_ops_done", 64'(ops_done), 64'd0);
        chk("mid_sticky", 64'(sticky_flags), 64'd0);
        chk("mid_rsp_id", 64'(rsp_id), 64'd0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        lat = 1;
        repeat (3) @(negedge ap_clk);
        chk("mid_no_stale", 64'(rsp_valid), 64'd0);
        op(0, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 32'h0);
        chk("mid_ops_done_after", 64'(ops_done), 64'd1);

        do_reset();
        n0 = gv.size();
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 13'h3FE, 64'h4000_0000_0000_0000);
        rsp_ready = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge ap_clk);
            if (gv.size() >= n0 + 5) break;
        end
        req_valid = '0;
        repeat (12) @(negedge ap_clk);
        rsp_ready = 1'b0;
        chk("cont_pulses", 64'(gv.size() - n0), 64'd5);
        for (int k = 0; k < 5; k++)
            if (n0 + k < gv.size())
                chk($sformatf("cont_order%0d", k), 64'(gv[n0 + k]), 64'(1 << (k % N)));
        // engine model: done two cycles after start, so grants repeat every 2+3 cycles
        if (n0 + 1 < gc.size()) chk("cont_period", 64'(gc[n0 + 1] - gc[n0]), 64'd5);
        chk("cont_ops_done", 64'(ops_done), 64'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
